bht_update_unit: RTL and testbench

- Consumer end of the branch-resolution interface: takes resolved-branch updates from the execute stage and maintains a table of 2-bit saturating direction counters.
- Answers same-cycle direction predictions for the frontend PC.
- Sits in the frontend beside the BTB.
- Table is cleared by a sequential init walk after reset or flush.

---
 rtl/bht_update_unit.sv | 161 ++++++++++++++++
 tb/tb_bht_update_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_unit.sv
// Branch history table: 2-bit saturating direction counters updated from execute-stage resolutions.
// Optional statistics counters are enabled with `define BHT_STATS_EN.
module bht_update_unit #(
   parameter int NR_ENTRIES = 64,
   parameter int VLEN       = 39
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            debug_mode_i,
   input  logic [VLEN-1:0] vpc_i,
   output logic            bht_valid_o,
   output logic            bht_taken_o,
   input  logic            res_valid_i,
   input  logic [VLEN-1:0] res_pc_i,
   input  logic            res_is_branch_i,
   input  logic            res_taken_i,
   input  logic            res_mispredict_i,
   output logic            init_done_o
`ifdef BHT_STATS_EN
   ,
   output logic [31:0]     upd_cnt_o,
   output logic [31:0]     mispred_cnt_o
`endif
);

   localparam int IDX = $clog2(NR_ENTRIES);

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   state_e         state_r, state_nxt_s;
   logic [IDX-1:0] init_cnt_r, init_cnt_nxt_s;
   logic           valid_r [NR_ENTRIES];
   logic [1:0]     ctr_r   [NR_ENTRIES];
   logic           stg_valid_r;
   logic [IDX-1:0] stg_idx_r;
   logic           stg_taken_r;
   logic [IDX-1:0] rd_idx_s;
   logic [IDX-1:0] res_idx_s;
   logic           capture_s;
   logic           unused_s;

   // A fresh entry starts weakly biased towards the first observed outcome.
   function automatic logic [1:0] ctr_next(input logic valid, input logic [1:0] ctr, input logic taken);
      if (!valid) begin
         ctr_next = taken ? 2'b10 : 2'b01;
      end else if (taken) begin
         ctr_next = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         ctr_next = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
   endfunction

   assign rd_idx_s  = vpc_i[IDX:1];
   assign res_idx_s = res_pc_i[IDX:1];

   assign init_done_o = (state_r == READY);
   assign bht_valid_o = init_done_o & valid_r[rd_idx_s];
   assign bht_taken_o = bht_valid_o & ctr_r[rd_idx_s][1];

   assign capture_s = res_valid_i & res_is_branch_i & ~debug_mode_i & init_done_o & ~flush_i;

   // FSM state and init-walk pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= INIT;
         init_cnt_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         init_cnt_r <= init_cnt_nxt_s;
      end
   end

   // Next-state logic: the walk restarts whenever a flush arrives.
   always_comb begin
      state_nxt_s    = state_r;
      init_cnt_nxt_s = init_cnt_r;
      case (state_r)
         INIT: begin
            if (flush_i) begin
               init_cnt_nxt_s = '0;
            end else if (init_cnt_r == IDX'(NR_ENTRIES - 1)) begin
               state_nxt_s    = READY;
               init_cnt_nxt_s = '0;
            end else begin
               init_cnt_nxt_s = init_cnt_r + IDX'(1);
            end
         end
         READY: begin
            if (flush_i) begin
               state_nxt_s    = INIT;
               init_cnt_nxt_s = '0;
            end else begin
               state_nxt_s    = READY;
            end
         end
         default: begin
            state_nxt_s    = INIT;
            init_cnt_nxt_s = '0;
         end
      endcase
   end

   // Stage 1: capture an accepted resolution.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_valid_r <= 1'b0;
         stg_idx_r   <= '0;
         stg_taken_r <= 1'b0;
      end else begin
         stg_valid_r <= capture_s;
         if (capture_s) begin
            stg_idx_r   <= res_idx_s;
            stg_taken_r <= res_taken_i;
         end else begin
            stg_idx_r   <= stg_idx_r;
            stg_taken_r <= stg_taken_r;
         end
      end
   end

   // Stage 2 / init walk: table write; a concurrent flush drops the staged write.
   always_ff @(posedge clk_i) begin
      if (state_r == INIT) begin
         valid_r[init_cnt_r] <= 1'b0;
         ctr_r[init_cnt_r]   <= 2'b00;
      end else if (stg_valid_r && !flush_i && !rst_i) begin
         valid_r[stg_idx_r] <= 1'b1;
         ctr_r[stg_idx_r]   <= ctr_next(valid_r[stg_idx_r], ctr_r[stg_idx_r], stg_taken_r);
      end
   end

`ifdef BHT_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Statistics survive flushes; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         upd_cnt_o     <= 32'd0;
         mispred_cnt_o <= 32'd0;
      end else if (capture_s) begin
         upd_cnt_o     <= sat_inc(upd_cnt_o);
         mispred_cnt_o <= res_mispredict_i ? sat_inc(mispred_cnt_o) : mispred_cnt_o;
      end else begin
         upd_cnt_o     <= upd_cnt_o;
         mispred_cnt_o <= mispred_cnt_o;
      end
   end

   assign unused_s = ^{vpc_i[VLEN-1:IDX+1], vpc_i[0], res_pc_i[VLEN-1:IDX+1], res_pc_i[0]};
`else
   assign unused_s = ^{vpc_i[VLEN-1:IDX+1], vpc_i[0], res_pc_i[VLEN-1:IDX+1], res_pc_i[0],
                       res_mispredict_i};
`endif

endmodule

// File: tb/tb_bht_update_unit.sv
// Randomized self-checking bench for bht_update_unit against a per-edge behavioural model.
module tb_bht_update_unit;
   localparam int N    = 64;
   localparam int VLEN = 39;

   logic            clk_s = 1'b0;
   logic            rst_s, flush_s, debug_s;
   logic [VLEN-1:0] vpc_s, res_pc_s;
   logic            res_valid_s, res_branch_s, res_taken_s, res_mis_s;
   logic            bht_valid_s, bht_taken_s, init_done_s;
`ifdef BHT_STATS_EN
   logic [31:0]     upd_cnt_s, mispred_cnt_s;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit      m_valid [N];
   int      m_ctr   [N];
   bit      m_done;
   int      m_left;
   bit      m_st_v;
   int      m_st_idx;
   bit      m_st_taken;
   longint  m_upd, m_mis;

   always #5 clk_s = ~clk_s;

   bht_update_unit #(.NR_ENTRIES(N), .VLEN(VLEN)) dut (
      .clk_i(clk_s), .rst_i(rst_s), .flush_i(flush_s), .debug_mode_i(debug_s),
      .vpc_i(vpc_s), .bht_valid_o(bht_valid_s), .bht_taken_o(bht_taken_s),
      .res_valid_i(res_valid_s), .res_pc_i(res_pc_s), .res_is_branch_i(res_branch_s),
      .res_taken_i(res_taken_s), .res_mispredict_i(res_mis_s), .init_done_o(init_done_s)
`ifdef BHT_STATS_EN
      , .upd_cnt_o(upd_cnt_s), .mispred_cnt_o(mispred_cnt_s)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [VLEN-1:0] pc);
      return int'((pc >> 1) % N);
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit cap;
      int i;
      cap = res_valid_s && res_branch_s && !debug_s && m_done && !flush_s;
      if (rst_s) begin
         m_done = 0; m_left = N; m_st_v = 0; m_upd = 0; m_mis = 0;
      end else begin
         if (m_done && m_st_v && !flush_s) begin
            i = m_st_idx;
            if (!m_valid[i]) begin
               m_valid[i] = 1;
               m_ctr[i]   = m_st_taken ? 2 : 1;
            end else if (m_st_taken) begin
               m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end
         if (cap) begin
            if (m_upd < 64'hFFFF_FFFF) m_upd++;
            if (res_mis_s && m_mis < 64'hFFFF_FFFF) m_mis++;
         end
         if (flush_s) begin
            m_done = 0; m_left = N;
         end else if (!m_done) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               foreach (m_valid[k]) begin m_valid[k] = 0; m_ctr[k] = 0; end
            end
         end
         m_st_v     = cap;
         m_st_idx   = idx_of(res_pc_s);
         m_st_taken = res_taken_s;
      end
   endtask

   // Compare outputs against the model, then take one clock edge.
   task automatic step();
      bit ev;
      #1;
      ev = m_done && m_valid[idx_of(vpc_s)];
      check_val("init_done", {31'd0, init_done_s}, {31'd0, m_done});
      check_val("bht_valid", {31'd0, bht_valid_s}, {31'd0, ev});
      check_val("bht_taken", {31'd0, bht_taken_s}, {31'd0, ev && (m_ctr[idx_of(vpc_s)] >= 2)});
`ifdef BHT_STATS_EN
      check_val("upd_cnt", upd_cnt_s, m_upd[31:0]);
      check_val("mispred_cnt", mispred_cnt_s, m_mis[31:0]);
`endif
      @(posedge clk_s);
      model_edge();
      #1;
   endtask

   task automatic upd(input logic [VLEN-1:0] pc, input logic taken, input logic br,
                      input logic dbg, input logic mis);
      res_valid_s = 1'b1; res_pc_s = pc; res_taken_s = taken;
      res_branch_s = br; debug_s = dbg; res_mis_s = mis;
      step();
      res_valid_s = 1'b0; debug_s = 1'b0; res_mis_s = 1'b0;
   endtask

   task automatic wait_init(output int cnt);
      cnt = 0;
      while (!init_done_s && cnt < 200) begin
         vpc_s = VLEN'($urandom_range(0, 255));
         step();
         cnt++;
      end
   endtask

   task automatic probe(input string tag, input logic [VLEN-1:0] pc, input logic [1:0] exp);
      vpc_s = pc;
      #1;
      check_val(tag, {30'd0, bht_valid_s, bht_taken_s}, {30'd0, exp});
   endtask

   initial begin
      int cnt;
      rst_s = 1'b1; flush_s = 1'b0; debug_s = 1'b0; vpc_s = '0; res_pc_s = '0;
      res_valid_s = 1'b0; res_branch_s = 1'b1; res_taken_s = 1'b0; res_mis_s = 1'b0;
      foreach (m_valid[k]) begin m_valid[k] = 0; m_ctr[k] = 0; end
      @(posedge clk_s); model_edge(); #1;

      // Reset and init latency
      repeat (3) step();
      rst_s = 1'b0;
      wait_init(cnt);
      check_val("init_latency", 32'(cnt), 32'd64);

      // First update and saturation
      upd(39'h80, 1'b1, 1'b1, 1'b0, 1'b0);
      vpc_s = 39'h80;
      step();
      probe("first_taken", 39'h80, 2'b11);
      upd(39'h80, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) upd(39'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      probe("sat_low", 39'h80, 2'b10);

      // Filtering and aliasing
      upd(39'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      upd(39'h80, 1'b1, 1'b1, 1'b1, 1'b0);
      step(); step();
      probe("filtered", 39'h80, 2'b10);
      upd(39'h80 + 39'd128, 1'b1, 1'b1, 1'b0, 1'b0);
      upd(39'h80 + 39'd128, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      probe("alias", 39'h80, 2'b11);

      // Flush collides with staged write
      upd(39'h100, 1'b1, 1'b1, 1'b0, 1'b0);
      flush_s = 1'b1; step(); flush_s = 1'b0;
      wait_init(cnt);
      check_val("flush_init_latency", 32'(cnt), 32'd64);
      probe("flush_discard", 39'h100, 2'b00);

      // Reset in the middle of the walk
      flush_s = 1'b1; step(); flush_s = 1'b0;
      repeat (30) step();
      rst_s = 1'b1; step(); rst_s = 1'b0;
      wait_init(cnt);
      check_val("reset_mid_init", 32'(cnt), 32'd64);

`ifdef BHT_STATS_EN
      rst_s = 1'b1; step(); rst_s = 1'b0;
      wait_init(cnt);
      for (int i = 0; i < 5; i++) upd(39'h40 + 39'(2 * i), 1'b1, 1'b1, 1'b0, (i < 2) ? 1'b1 : 1'b0);
      flush_s = 1'b1; step(); flush_s = 1'b0;
      step();
      check_val("stats_upd_kept", upd_cnt_s, 32'd5);
      check_val("stats_mis_kept", mispred_cnt_s, 32'd2);
      rst_s = 1'b1; step(); rst_s = 1'b0;
      check_val("stats_upd_rst", upd_cnt_s, 32'd0);
      check_val("stats_mis_rst", mispred_cnt_s, 32'd0);
      wait_init(cnt);
`endif

      // Randomized traffic over a small, aliasing address set
      for (int c = 0; c < 3000; c++) begin
         rst_s        = ($urandom_range(0, 499) == 0);
         flush_s      = ($urandom_range(0, 149) == 0);
         debug_s      = ($urandom_range(0, 9) == 0);
         res_valid_s  = ($urandom_range(0, 3) != 0);
         res_branch_s = ($urandom_range(0, 3) != 0);
         res_taken_s  = $urandom_range(0, 1);
         res_mis_s    = $urandom_range(0, 1);
         res_pc_s     = 39'h1000 + 39'($urandom_range(0, 7) * 2) + 39'($urandom_range(0, 1) * 128)
                        + 39'($urandom_range(0, 1));
         vpc_s        = 39'h1000 + 39'($urandom_range(0, 7) * 2) + 39'($urandom_range(0, 1));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
